irq_request_latch: RTL and testbench

- Front-end stage for the 8-to-3 priority encoder.
- Synchronises eight asynchronous request lines, detects events, and holds them in a pending register with per-line masking.
- Presents the highest-index enabled pending line as a 3-bit ID over a valid/ready handshake.
- Retires each request only when the consumer accepts it.

---
 rtl/irq_request_latch_pkg.sv | 19 +
 rtl/irq_request_latch_prienc.sv | 19 +
 rtl/irq_request_latch.sv | 145 ++++++++++++++
 tb/tb_irq_request_latch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_request_latch_pkg.sv
// Shared types and constants for the interrupt request latch front-end.
package irq_request_latch_pkg;

  localparam int IRQ_W    = 8;
  localparam int IRQ_ID_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_e;

  function automatic logic [IRQ_W-1:0] id_to_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_W-1:0] oh;
    oh     = {IRQ_W{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_request_latch_prienc.sv
// 8-to-3 priority encoder: highest set index wins; all-zero input yields 0.
module priority_encoder_8_to_3 (
  input  logic [7:0] din,
  output logic [2:0] dout
);

  // Scan upwards so the last (highest) set bit determines the result.
  always_comb begin
    dout = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (din[i]) begin
        dout = i[2:0];
      end else begin
        dout = dout;
      end
    end
  end

endmodule

// File: rtl/irq_request_latch.sv
// Synchronises eight request lines, latches events as pending and offers the
// highest enabled pending line over a valid/ready handshake.
module irq_request_latch
  import irq_request_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IRQ_W-1:0]    irq_in,
  input  logic [IRQ_W-1:0]    mask,
  input  logic                clr_all,
  input  logic                req_ready,
  output logic                req_valid,
  output logic [IRQ_ID_W-1:0] req_id,
  output logic [IRQ_W-1:0]    pending,
  output logic [IRQ_W-1:0]    overrun
);

  logic [IRQ_W-1:0]    sync_r [SYNC_STAGES];
  logic [IRQ_W-1:0]    sync_s;
  logic [IRQ_W-1:0]    sync_d_r;
  logic [IRQ_W-1:0]    evt_s;
  logic [IRQ_W-1:0]    ret_s;
  logic [IRQ_W-1:0]    masked_s;
  logic [IRQ_ID_W-1:0] enc_id_s;
  logic [IRQ_W-1:0]    pending_r, pending_d;
  logic [IRQ_W-1:0]    overrun_r, overrun_d;
  irq_state_e          state_r, state_d;
  logic                req_valid_r, req_valid_d;
  logic [IRQ_ID_W-1:0] req_id_r, req_id_d;

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    // One synchroniser stage for all request lines.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_r[g] <= {IRQ_W{1'b0}};
      end else if (g == 0) begin
        sync_r[g] <= irq_in;
      end else begin
        sync_r[g] <= sync_r[(g == 0) ? 0 : g-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Edge-history register used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_d_r <= {IRQ_W{1'b0}};
    end else begin
      sync_d_r <= sync_s;
    end
  end

  // Event detection: rising edge or plain level depending on EDGE_MODE.
  always_comb begin
    if (EDGE_MODE) begin
      evt_s = sync_s & ~sync_d_r;
    end else begin
      evt_s = sync_s;
    end
  end

  assign masked_s = pending_r & mask;

  priority_encoder_8_to_3 u_prienc (
    .din  (masked_s),
    .dout (enc_id_s)
  );

  // Pending/overrun next state; a same-cycle event beats the retire of its bit.
  always_comb begin
    ret_s     = {IRQ_W{1'b0}};
    pending_d = pending_r;
    overrun_d = overrun_r;
    if (req_valid_r && req_ready) begin
      ret_s = id_to_onehot(req_id_r);
    end else begin
      ret_s = {IRQ_W{1'b0}};
    end
    if (clr_all) begin
      pending_d = {IRQ_W{1'b0}};
      overrun_d = {IRQ_W{1'b0}};
    end else begin
      pending_d = (pending_r & ~ret_s) | evt_s;
      overrun_d = overrun_r | (evt_s & pending_r & ~ret_s);
    end
  end

  // Offer FSM: the ID is frozen while offered; only accept or flush ends it.
  always_comb begin
    state_d     = state_r;
    req_valid_d = req_valid_r;
    req_id_d    = req_id_r;
    case (state_r)
      IDLE: begin
        if ((masked_s != {IRQ_W{1'b0}}) && !clr_all) begin
          state_d     = OFFER;
          req_valid_d = 1'b1;
          req_id_d    = enc_id_s;
        end else begin
          req_valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (req_ready || clr_all) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
        end else begin
          req_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_valid_r <= 1'b0;
      req_id_r    <= {IRQ_ID_W{1'b0}};
      pending_r   <= {IRQ_W{1'b0}};
      overrun_r   <= {IRQ_W{1'b0}};
    end else begin
      state_r     <= state_d;
      req_valid_r <= req_valid_d;
      req_id_r    <= req_id_d;
      pending_r   <= pending_d;
      overrun_r   <= overrun_d;
    end
  end

  assign req_valid = req_valid_r;
  assign req_id    = req_id_r;
  assign pending   = pending_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_irq_request_latch.sv
// Directed self-checking bench for irq_request_latch (default parameters).
module tb_irq_request_latch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       clr_all;
  logic       req_ready;
  logic       req_valid;
  logic [2:0] req_id;
  logic [7:0] pending;
  logic [7:0] overrun;

  int checks = 0;
  int errors = 0;

  irq_request_latch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .mask      (mask),
    .clr_all   (clr_all),
    .req_ready (req_ready),
    .req_valid (req_valid),
    .req_id    (req_id),
    .pending   (pending),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise lines v at the current negedge, hold for two sampling edges, drop.
  task automatic pulse(input logic [7:0] v);
    irq_in = v;
    idle(2);
    irq_in = 8'h00;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; irq_in = 8'h00; mask = 8'hFF; clr_all = 1'b0; req_ready = 1'b1;
    idle(2);
    checks++;
    if ({req_valid, req_id, pending, overrun} !== {1'b0, 3'd0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%0d p=%h o=%h, want 0/0/00/00", req_valid, req_id, pending, overrun);
    end
    rst_n = 1'b1;
    idle(3);
  endtask

  task automatic test_single_pulse;
    req_ready = 1'b1;
    pulse(8'h04);
    idle(1);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h04}) begin
      errors++;
      $display("FAIL single_e3: got v=%b p=%h, want 0/04", req_valid, pending);
    end
    idle(1);
    checks++;
    if ({req_valid, req_id, pending, overrun} !== {1'b1, 3'd2, 8'h04, 8'h00}) begin
      errors++;
      $display("FAIL single_offer: got v=%b id=%0d p=%h o=%h, want 1/2/04/00", req_valid, req_id, pending, overrun);
    end
    idle(1);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_retire: got v=%b p=%h, want 0/00", req_valid, pending);
    end
    idle(4);
  endtask

  task automatic test_priority;
    logic [2:0] exp_id [3];
    logic [7:0] exp_p  [3];
    exp_id[0] = 3'd7; exp_id[1] = 3'd5; exp_id[2] = 3'd1;
    exp_p[0]  = 8'hA2; exp_p[1] = 8'h22; exp_p[2] = 8'h02;
    req_ready = 1'b1;
    pulse(8'hA2);
    idle(1);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      checks++;
      if ({req_valid, req_id, pending} !== {1'b1, exp_id[k], exp_p[k]}) begin
        errors++;
        $display("FAIL prio_offer%0d: got v=%b id=%0d p=%h, want 1/%0d/%h", k, req_valid, req_id, pending, exp_id[k], exp_p[k]);
      end
      idle(1);
      checks++;
      if (req_valid !== 1'b0) begin
        errors++;
        $display("FAIL prio_gap%0d: got v=%b, want 0", k, req_valid);
      end
    end
    checks++;
    if (pending !== 8'h00) begin
      errors++;
      $display("FAIL prio_end: got p=%h, want 00", pending);
    end
    idle(4);
  endtask

  task automatic test_backpressure;
    req_ready = 1'b0;
    pulse(8'h08);
    idle(2);
    checks++;
    if ({req_valid, req_id, pending} !== {1'b1, 3'd3, 8'h08}) begin
      errors++;
      $display("FAIL bp_offer: got v=%b id=%0d p=%h, want 1/3/08", req_valid, req_id, pending);
    end
    pulse(8'h40);
    for (int k = 0; k < 2; k++) begin
      idle(1);
      checks++;
      if ({req_valid, req_id, pending} !== {1'b1, 3'd3, 8'h48}) begin
        errors++;
        $display("FAIL bp_hold%0d: got v=%b id=%0d p=%h, want 1/3/48", k, req_valid, req_id, pending);
      end
    end
    req_ready = 1'b1;
    idle(1);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h40}) begin
      errors++;
      $display("FAIL bp_accept: got v=%b p=%h, want 0/40", req_valid, pending);
    end
    idle(1);
    checks++;
    if ({req_valid, req_id} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL bp_next: got v=%b id=%0d, want 1/6", req_valid, req_id);
    end
    idle(1);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL bp_end: got v=%b p=%h, want 0/00", req_valid, pending);
    end
    idle(4);
  endtask

  task automatic test_masking;
    req_ready = 1'b1;
    mask = 8'hEF;
    pulse(8'h10);
    for (int k = 0; k < 3; k++) begin
      idle(1);
      checks++;
      if ({req_valid, pending} !== {1'b0, 8'h10}) begin
        errors++;
        $display("FAIL mask_hold%0d: got v=%b p=%h, want 0/10", k, req_valid, pending);
      end
    end
    mask = 8'hFF;
    idle(1);
    checks++;
    if ({req_valid, req_id, pending} !== {1'b1, 3'd4, 8'h10}) begin
      errors++;
      $display("FAIL mask_offer: got v=%b id=%0d p=%h, want 1/4/10", req_valid, req_id, pending);
    end
    idle(1);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL mask_retire: got v=%b p=%h, want 0/00", req_valid, pending);
    end
    idle(4);
  endtask

  task automatic test_overrun;
    req_ready = 1'b0;
    pulse(8'h04);
    idle(2);
    checks++;
    if ({req_valid, req_id, pending, overrun} !== {1'b1, 3'd2, 8'h04, 8'h00}) begin
      errors++;
      $display("FAIL ovr_offer: got v=%b id=%0d p=%h o=%h, want 1/2/04/00", req_valid, req_id, pending, overrun);
    end
    idle(2);
    irq_in = 8'h04;
    idle(2);
    irq_in = 8'h00;
    req_ready = 1'b1;
    idle(1);
    checks++;
    if ({req_valid, pending, overrun} !== {1'b0, 8'h04, 8'h00}) begin
      errors++;
      $display("FAIL ovr_setwins: got v=%b p=%h o=%h, want 0/04/00", req_valid, pending, overrun);
    end
    req_ready = 1'b0;
    idle(1);
    checks++;
    if ({req_valid, req_id, pending} !== {1'b1, 3'd2, 8'h04}) begin
      errors++;
      $display("FAIL ovr_reoffer: got v=%b id=%0d p=%h, want 1/2/04", req_valid, req_id, pending);
    end
    irq_in = 8'h04;
    idle(2);
    irq_in = 8'h00;
    idle(1);
    checks++;
    if ({req_valid, req_id, pending, overrun} !== {1'b1, 3'd2, 8'h04, 8'h04}) begin
      errors++;
      $display("FAIL ovr_sticky: got v=%b id=%0d p=%h o=%h, want 1/2/04/04", req_valid, req_id, pending, overrun);
    end
    clr_all = 1'b1;
    idle(1);
    checks++;
    if ({req_valid, pending, overrun} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL ovr_clr: got v=%b p=%h o=%h, want 0/00/00", req_valid, pending, overrun);
    end
    clr_all = 1'b0;
    idle(4);
  endtask

  task automatic test_async_reset;
    req_ready = 1'b0;
    pulse(8'h80);
    idle(2);
    checks++;
    if ({req_valid, req_id, pending} !== {1'b1, 3'd7, 8'h80}) begin
      errors++;
      $display("FAIL arst_pre: got v=%b id=%0d p=%h, want 1/7/80", req_valid, req_id, pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_valid, req_id, pending, overrun} !== {1'b0, 3'd0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL arst_now: got v=%b id=%0d p=%h o=%h, want 0/0/00/00", req_valid, req_id, pending, overrun);
    end
    idle(1);
    rst_n = 1'b1;
    idle(3);
    checks++;
    if ({req_valid, pending} !== {1'b0, 8'h00}) begin
      errors++;
      $display("FAIL arst_after: got v=%b p=%h, want 0/00", req_valid, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_priority();
    test_backpressure();
    test_masking();
    test_overrun();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
